// File: rtl/world_clock_pkg.sv
// Shared world-clock types and hour/minute helpers: canonical 12h form,
// conversions to and from 24h, and field stepping.
package world_clock_pkg;

    localparam int unsigned HOURS_PER_DAY = 24;
    localparam int unsigned MIN_PER_HOUR  = 60;
    localparam int unsigned NOON_HOUR     = 12;
    localparam int unsigned HOUR_W        = 5;
    localparam int unsigned MIN_W         = 6;

    typedef enum logic [1:0] {
        IDLE,
        EDIT_HOUR,
        EDIT_MIN,
        COMMIT
    } set_state_e;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic              pm;
    } h12_t;

    // Out-of-range hours are treated as midnight.
    function automatic h12_t to_h12(input logic [HOUR_W-1:0] h24);
        h12_t r;
        r.hour = '0;
        r.pm   = 1'b0;
        if (h24 < HOUR_W'(NOON_HOUR)) begin
            r.hour = h24;
        end else if (h24 == HOUR_W'(NOON_HOUR)) begin
            r.hour = HOUR_W'(NOON_HOUR);
            r.pm   = 1'b1;
        end else if (h24 < HOUR_W'(HOURS_PER_DAY)) begin
            r.hour = h24 - HOUR_W'(NOON_HOUR);
            r.pm   = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [HOUR_W-1:0] to_h24(input h12_t t);
        logic [HOUR_W-1:0] h;
        if (!t.pm || t.hour == HOUR_W'(NOON_HOUR)) h = t.hour;
        else                                        h = t.hour + HOUR_W'(NOON_HOUR);
        return h;
    endfunction

    // Stepping in 24h space gives the AM 0..11 -> PM 12,1..11 -> AM 0 order.
    function automatic h12_t step_hour(input h12_t t, input logic up);
        logic [HOUR_W-1:0] h;
        h = to_h24(t);
        if (up) h = (h == HOUR_W'(HOURS_PER_DAY - 1)) ? '0 : h + HOUR_W'(1);
        else    h = (h == '0) ? HOUR_W'(HOURS_PER_DAY - 1) : h - HOUR_W'(1);
        return to_h12(h);
    endfunction

    function automatic logic [MIN_W-1:0] step_min(input logic [MIN_W-1:0] m, input logic up);
        logic [MIN_W-1:0] r;
        if (up) r = (m == MIN_W'(MIN_PER_HOUR - 1)) ? '0 : m + MIN_W'(1);
        else    r = (m == '0) ? MIN_W'(MIN_PER_HOUR - 1) : m - MIN_W'(1);
        return r;
    endfunction

    function automatic h12_t toggle_ampm(input h12_t t);
        h12_t r;
        r = t;
        if (!t.pm) begin
            r.pm = 1'b1;
            if (t.hour == '0) r.hour = HOUR_W'(NOON_HOUR);
        end else begin
            r.pm = 1'b0;
            if (t.hour == HOUR_W'(NOON_HOUR)) r.hour = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/hour_set_12_24_btn_step.sv
// Per-button step pulse: rising-edge detect, plus hold auto-repeat when
// HOLD_REPEAT_EN is defined.
module btn_step (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic step_c
);

`ifdef HOLD_REPEAT_EN
    parameter int unsigned REPEAT_DELAY = 32'd50_000_000;
    parameter int unsigned REPEAT_RATE  = 32'd10_000_000;
`endif

    logic btn_q;
    logic edge_c;

    always_ff @(posedge clk) begin
        if (rst) btn_q <= 1'b0;
        else     btn_q <= btn;
    end

    assign edge_c = btn & ~btn_q;

`ifdef HOLD_REPEAT_EN
    logic [31:0] hold_cnt_q;
    logic        repeating_q;
    logic        repeat_c;

    // First repeat after REPEAT_DELAY held cycles, then every REPEAT_RATE.
    assign repeat_c = btn & btn_q &
        (hold_cnt_q == (repeating_q ? 32'(REPEAT_RATE - 1) : 32'(REPEAT_DELAY - 1)));

    always_ff @(posedge clk) begin
        if (rst || !btn) begin
            hold_cnt_q  <= '0;
            repeating_q <= 1'b0;
        end else if (repeat_c) begin
            hold_cnt_q  <= '0;
            repeating_q <= 1'b1;
        end else begin
            hold_cnt_q  <= hold_cnt_q + 32'd1;
        end
    end

    assign step_c = edge_c | repeat_c;
`else
    assign step_c = edge_c;
`endif

endmodule

// File: rtl/hour_set_12_24.sv
// Hour/minute set controller editing in 12h or 24h form, committing in 24h.
// Optional hold auto-repeat on inc/dec via HOLD_REPEAT_EN.
module hour_set_12_24 #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd500_000_000
`ifdef HOLD_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY   = 32'd50_000_000,
    parameter int unsigned REPEAT_RATE    = 32'd10_000_000
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_12h,
    input  logic       btn_set,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       btn_ampm,
    input  logic [4:0] cur_hour24,
    input  logic [5:0] cur_min,
    output logic [4:0] hour_disp,
    output logic       is_pm,
    output logic [5:0] min_disp,
    output logic       editing,
    output logic       edit_field,
    output logic       load,
    output logic [4:0] hour24_out,
    output logic [5:0] min_out
);
    import world_clock_pkg::*;

    set_state_e        state_q, state_d;
    h12_t              edit_q, edit_d, disp_c;
    logic [MIN_W-1:0]  min_q, min_d;
    logic [31:0]       idle_cnt_q, idle_cnt_d;
    logic              set_q, ampm_q;
    logic              set_edge, ampm_edge, inc_step, dec_step, any_edge;

    logic [HOUR_W-1:0] hour_disp_d, hour24_out_d;
    logic [MIN_W-1:0]  min_disp_d, min_out_d;
    logic              is_pm_d, editing_d, edit_field_d, load_d;

`ifdef HOLD_REPEAT_EN
    btn_step #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_inc (
        .clk(clk), .rst(rst), .btn(btn_inc), .step_c(inc_step));
    btn_step #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_dec (
        .clk(clk), .rst(rst), .btn(btn_dec), .step_c(dec_step));
`else
    btn_step u_inc (.clk(clk), .rst(rst), .btn(btn_inc), .step_c(inc_step));
    btn_step u_dec (.clk(clk), .rst(rst), .btn(btn_dec), .step_c(dec_step));
`endif

    assign set_edge  = btn_set & ~set_q;
    assign ampm_edge = btn_ampm & ~ampm_q;
    assign any_edge  = set_edge | ampm_edge | inc_step | dec_step;

    // Next state, edit registers and the registered output values.
    always_comb begin
        state_d      = state_q;
        edit_d       = edit_q;
        min_d        = min_q;
        idle_cnt_d   = '0;
        load_d       = 1'b0;
        hour24_out_d = hour24_out;
        min_out_d    = min_out;

        unique case (state_q)
            IDLE: begin
                if (set_edge) begin
                    state_d = EDIT_HOUR;
                    edit_d  = to_h12(cur_hour24);
                    min_d   = cur_min;
                end
            end
            EDIT_HOUR, EDIT_MIN: begin
                idle_cnt_d = any_edge ? '0 : idle_cnt_q + 32'd1;
                if (set_edge) begin
                    state_d = (state_q == EDIT_HOUR) ? EDIT_MIN : COMMIT;
                end else begin
                    if (state_q == EDIT_HOUR) begin
                        if (ampm_edge && mode_12h) edit_d = toggle_ampm(edit_d);
                        if (inc_step ^ dec_step)   edit_d = step_hour(edit_d, inc_step);
                    end else if (inc_step ^ dec_step) begin
                        min_d = step_min(min_q, inc_step);
                    end
                    if (!any_edge && idle_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                        state_d    = IDLE;
                        idle_cnt_d = '0;
                    end
                end
                if (state_d == COMMIT) begin
                    load_d       = 1'b1;
                    hour24_out_d = to_h24(edit_q);
                    min_out_d    = min_q;
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        disp_c       = (state_d == IDLE) ? to_h12(cur_hour24) : edit_d;
        min_disp_d   = (state_d == IDLE) ? cur_min : min_d;
        hour_disp_d  = mode_12h ? disp_c.hour : to_h24(disp_c);
        is_pm_d      = mode_12h & disp_c.pm;
        editing_d    = (state_d == EDIT_HOUR) || (state_d == EDIT_MIN);
        edit_field_d = (state_d == EDIT_MIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            edit_q     <= '0;
            min_q      <= '0;
            idle_cnt_q <= '0;
            set_q      <= 1'b0;
            ampm_q     <= 1'b0;
            hour_disp  <= '0;
            is_pm      <= 1'b0;
            min_disp   <= '0;
            editing    <= 1'b0;
            edit_field <= 1'b0;
            load       <= 1'b0;
            hour24_out <= '0;
            min_out    <= '0;
        end else begin
            state_q    <= state_d;
            edit_q     <= edit_d;
            min_q      <= min_d;
            idle_cnt_q <= idle_cnt_d;
            set_q      <= btn_set;
            ampm_q     <= btn_ampm;
            hour_disp  <= hour_disp_d;
            is_pm      <= is_pm_d;
            min_disp   <= min_disp_d;
            editing    <= editing_d;
            edit_field <= edit_field_d;
            load       <= load_d;
            hour24_out <= hour24_out_d;
            min_out    <= min_out_d;
        end
    end

endmodule

// File: tb/tb_hour_set_12_24.sv
// Self-checking bench for hour_set_12_24: directed scenarios plus random
// button traffic against a 24h-arithmetic reference model.
module tb_hour_set_12_24;

    localparam int unsigned TO = 20;

    logic       clk = 1'b0;
    logic       rst, mode_12h, btn_set, btn_inc, btn_dec, btn_ampm;
    logic [4:0] cur_hour24;
    logic [5:0] cur_min;
    logic [4:0] hour_disp, hour24_out;
    logic [5:0] min_disp, min_out;
    logic       is_pm, editing, edit_field, load;

    always #5 clk = ~clk;

    hour_set_12_24 #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .mode_12h(mode_12h),
        .btn_set(btn_set), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_ampm(btn_ampm),
        .cur_hour24(cur_hour24), .cur_min(cur_min),
        .hour_disp(hour_disp), .is_pm(is_pm), .min_disp(min_disp),
        .editing(editing), .edit_field(edit_field), .load(load),
        .hour24_out(hour24_out), .min_out(min_out)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: hour kept as a plain 0..23 value, state as 0..3.
    int m_state, m_h24, m_min, m_quiet;
    bit p_set, p_inc, p_dec, p_ampm;
    int e_hour_disp, e_is_pm, e_min_disp, e_editing, e_field, e_load, e_h24out, e_minout;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update();
        bit se, ie, de, ae, any;
        int h;
        if (rst) begin
            m_state = 0; m_h24 = 0; m_min = 0; m_quiet = 0;
            p_set = 0; p_inc = 0; p_dec = 0; p_ampm = 0;
            e_hour_disp = 0; e_is_pm = 0; e_min_disp = 0; e_editing = 0;
            e_field = 0; e_load = 0; e_h24out = 0; e_minout = 0;
            return;
        end
        se = btn_set && !p_set;
        ie = btn_inc && !p_inc;
        de = btn_dec && !p_dec;
        ae = btn_ampm && !p_ampm;
        any = se || ie || de || ae;
        e_load = 0;
        case (m_state)
            0: if (se) begin
                m_h24 = (cur_hour24 > 23) ? 0 : int'(cur_hour24);
                m_min = int'(cur_min);
                m_state = 1;
                m_quiet = 0;
            end
            1, 2: begin
                if (se) begin
                    if (m_state == 2) begin
                        e_load = 1; e_h24out = m_h24; e_minout = m_min;
                    end
                    m_state = m_state + 1;
                    m_quiet = 0;
                end else begin
                    m_quiet = any ? 0 : m_quiet + 1;
                    if (m_state == 1) begin
                        if (ae && mode_12h) m_h24 = (m_h24 + 12) % 24;
                        if (ie && !de) m_h24 = (m_h24 + 1) % 24;
                        if (de && !ie) m_h24 = (m_h24 + 23) % 24;
                    end else begin
                        if (ie && !de) m_min = (m_min + 1) % 60;
                        if (de && !ie) m_min = (m_min + 59) % 60;
                    end
                    if (m_quiet == TO) begin
                        m_state = 0;
                        m_quiet = 0;
                    end
                end
            end
            default: m_state = 0;
        endcase
        p_set = btn_set; p_inc = btn_inc; p_dec = btn_dec; p_ampm = btn_ampm;

        if (m_state == 0) begin
            h = (cur_hour24 > 23) ? 0 : int'(cur_hour24);
            e_min_disp = int'(cur_min);
        end else begin
            h = m_h24;
            e_min_disp = m_min;
        end
        e_hour_disp = mode_12h ? ((h > 12) ? h - 12 : h) : h;
        e_is_pm     = (mode_12h && h >= 12) ? 1 : 0;
        e_editing   = (m_state == 1 || m_state == 2) ? 1 : 0;
        e_field     = (m_state == 2) ? 1 : 0;
    endtask

    // One clock: drive inputs, advance the model, compare after the edge.
    task automatic tick(input bit r, input bit s, input bit i, input bit d, input bit a);
        rst = r; btn_set = s; btn_inc = i; btn_dec = d; btn_ampm = a;
        model_update();
        @(posedge clk);
        #1;
        check_eq("hour_disp",  32'(hour_disp),  32'(e_hour_disp));
        check_eq("is_pm",      32'(is_pm),      32'(e_is_pm));
        check_eq("min_disp",   32'(min_disp),   32'(e_min_disp));
        check_eq("editing",    32'(editing),    32'(e_editing));
        check_eq("edit_field", 32'(edit_field), 32'(e_field));
        check_eq("load",       32'(load),       32'(e_load));
        check_eq("hour24_out", 32'(hour24_out), 32'(e_h24out));
        check_eq("min_out",    32'(min_out),    32'(e_minout));
    endtask

    task automatic press(input bit s, input bit i, input bit d, input bit a);
        tick(0, s, i, d, a);
        tick(0, 0, 0, 0, 0);
    endtask

    // Enter edit at hour h, step once (+1 inc / -1 dec), commit and check the result.
    task automatic hour_commit(input int h, input int dir, input int exp_h24, input int exp_h12, input int exp_pm);
        cur_hour24 = 5'(h);
        press(1, 0, 0, 0);
        tick(0, 0, dir > 0, dir < 0, 0);
        check_eq("step_h12", 32'(hour_disp), 32'(exp_h12));
        check_eq("step_pm",  32'(is_pm),     32'(exp_pm));
        tick(0, 0, 0, 0, 0);
        press(1, 0, 0, 0);
        tick(0, 1, 0, 0, 0);
        check_eq("commit_load", 32'(load),       32'd1);
        check_eq("commit_h24",  32'(hour24_out), 32'(exp_h24));
        tick(0, 0, 0, 0, 0);
        check_eq("load_1cyc", 32'(load), 32'd0);
        tick(0, 0, 0, 0, 0);
    endtask

    initial begin
        bit s, i, d, a;
        mode_12h = 1'b1; cur_hour24 = 5'd15; cur_min = 6'd30;
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        check_eq("rst_hour_disp", 32'(hour_disp), 32'd0);
        check_eq("rst_load",      32'(load),      32'd0);

        // Capture 15:30 in 12h form.
        tick(0, 1, 0, 0, 0);
        check_eq("cap_hour",  32'(hour_disp),  32'd3);
        check_eq("cap_pm",    32'(is_pm),      32'd1);
        check_eq("cap_edit",  32'(editing),    32'd1);
        check_eq("cap_field", 32'(edit_field), 32'd0);
        tick(1, 0, 0, 0, 0);

        hour_commit(11, 1, 12, 12, 1);
        hour_commit(12, 1, 13, 1, 1);
        hour_commit(23, 1, 0, 0, 0);
        hour_commit(0, -1, 23, 11, 1);

        // AM/PM toggling at midnight, then ignored in 24h mode.
        cur_hour24 = 5'd0;
        press(1, 0, 0, 0);
        tick(0, 0, 0, 0, 1);
        check_eq("ampm_to_pm_h", 32'(hour_disp), 32'd12);
        check_eq("ampm_to_pm",   32'(is_pm),     32'd1);
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 1);
        check_eq("ampm_to_am_h", 32'(hour_disp), 32'd0);
        check_eq("ampm_to_am",   32'(is_pm),     32'd0);
        tick(0, 0, 0, 0, 0);
        mode_12h = 1'b0;
        tick(0, 0, 0, 0, 1);
        check_eq("ampm_24h_h",  32'(hour_disp), 32'd0);
        check_eq("ampm_24h_pm", 32'(is_pm),     32'd0);
        tick(1, 0, 0, 0, 0);

        // Minute wrap 59 -> 0 with no hour carry.
        cur_hour24 = 5'd5; cur_min = 6'd59;
        press(1, 0, 0, 0);
        press(1, 0, 0, 0);
        tick(0, 0, 1, 0, 0);
        check_eq("min_wrap", 32'(min_disp),  32'd0);
        check_eq("min_hour", 32'(hour_disp), 32'd5);
        tick(0, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0);
        check_eq("min_load", 32'(load),    32'd1);
        check_eq("min_out",  32'(min_out), 32'd0);
        tick(0, 0, 0, 0, 0);
        check_eq("min_load_1cyc", 32'(load), 32'd0);
        tick(0, 0, 0, 0, 0);

        // Set wins over inc; reset mid-minute-edit gives no load.
        cur_hour24 = 5'd7;
        press(1, 0, 0, 0);
        tick(0, 1, 1, 0, 0);
        check_eq("setinc_field", 32'(edit_field), 32'd1);
        check_eq("setinc_hour",  32'(hour_disp),  32'd7);
        tick(0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        check_eq("rst_edit", 32'(editing), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick(0, 0, 0, 0, 0);
            check_eq("rst_noload", 32'(load), 32'd0);
        end

        // Timeout: quiet for TO cycles in EDIT_HOUR falls back to live time.
        cur_hour24 = 5'd9; cur_min = 6'd10;
        press(1, 0, 0, 0);
        cur_hour24 = 5'd14;
        for (int k = 0; k < int'(TO) - 2; k++) tick(0, 0, 0, 0, 0);
        check_eq("to_still_edit", 32'(editing), 32'd1);
        tick(0, 0, 0, 0, 0);
        check_eq("to_idle",  32'(editing),   32'd0);
        check_eq("to_live",  32'(hour_disp), 32'd14);
        check_eq("to_noload", 32'(load),     32'd0);

        // Random traffic checked every cycle against the model.
        s = 0; i = 0; d = 0; a = 0;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 5) == 0) s = ~s;
            if ($urandom_range(0, 4) == 0) i = ~i;
            if ($urandom_range(0, 4) == 0) d = ~d;
            if ($urandom_range(0, 6) == 0) a = ~a;
            if ($urandom_range(0, 63) == 0) mode_12h = ~mode_12h;
            if ($urandom_range(0, 15) == 0) begin
                cur_hour24 = ($urandom_range(0, 19) == 0) ? 5'($urandom_range(24, 31))
                                                          : 5'($urandom_range(0, 23));
                cur_min = 6'($urandom_range(0, 59));
            end
            if ($urandom_range(0, 40) == 0) begin
                s = 0; i = 0; d = 0; a = 0;
                for (int q = 0; q < int'(TO) + 2; q++) tick(0, 0, 0, 0, 0);
            end
            tick($urandom_range(0, 499) == 0, s, i, d, a);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
